// File: rtl/ccp_q_pkg.sv
// Shared types and sizing for the CCP cache->ctrl queue consumer.
package ccp_q_pkg;

   localparam int unsigned CCP_MEM_W = 4;
   localparam int unsigned STG_DEPTH = 2;
   localparam int unsigned STG_CNT_W = $clog2(STG_DEPTH + 1);

   typedef logic [CCP_MEM_W-1:0] ccp_q_entry_t;

   // Staging buffer occupancy; encoding equals the entry count.
   typedef enum logic [STG_CNT_W-1:0] {
      STG_EMPTY = 2'd0,
      STG_ONE   = 2'd1,
      STG_TWO   = 2'd2
   } ccp_stg_state_t;

   // Occupancy count carried by a staging state.
   function automatic logic [STG_CNT_W-1:0] stg_cnt(input ccp_stg_state_t s);
      return STG_CNT_W'(s);
   endfunction

endpackage

// File: rtl/ccp_skid_buf2.sv
// Two-entry FIFO staging buffer; head is combinational from registers.
module ccp_skid_buf2
   import ccp_q_pkg::*;
#(
   parameter int unsigned W = CCP_MEM_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr,
   input  logic                 rd,
   input  logic                 clr,
   input  logic [W-1:0]         wr_data,
   output logic [W-1:0]         head,
   output logic [STG_CNT_W-1:0] cnt
);

   logic [W-1:0]   mem_q [STG_DEPTH];
   logic           rd_ptr_q;
   logic           wr_ptr_q;
   ccp_stg_state_t state_q;
   ccp_stg_state_t state_d;

   // Occupancy state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= STG_EMPTY;
      else       state_q <= state_d;
   end

   // Occupancy next state: write grows, read shrinks, both keeps, clear empties.
   always_comb begin
      state_d = state_q;
      case (state_q)
         STG_EMPTY: if (wr)        state_d = STG_ONE;
         STG_ONE: begin
            if (wr && !rd)         state_d = STG_TWO;
            else if (rd && !wr)    state_d = STG_EMPTY;
         end
         STG_TWO:   if (rd && !wr) state_d = STG_ONE;
         default:                  state_d = STG_EMPTY;
      endcase
      if (clr) state_d = STG_EMPTY;
   end

   // Read/write pointers; a full buffer has both pointers equal.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
      end else begin
         if (wr) wr_ptr_q <= ~wr_ptr_q;
         if (rd) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   // Entry storage; when full a write lands in the slot being read out this cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(STG_DEPTH); i++) mem_q[i] <= '0;
      end else if (wr && !clr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign head = mem_q[rd_ptr_q];
   assign cnt  = stg_cnt(state_q);

endmodule

// File: rtl/ccp_ctrl_pop_stage.sv
// Pops the cache->ctrl queue, stages two entries and forwards them to ctrl under credits.
module ccp_ctrl_pop_stage
   import ccp_q_pkg::*;
#(
   parameter int unsigned MEM_W   = CCP_MEM_W,
   parameter int unsigned CREDITS = 4,
   parameter int unsigned SEQ_W   = 4,
   localparam int unsigned CRD_W  = $clog2(CREDITS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             q_empty,
   input  logic             q_push_any,
   input  logic [MEM_W-1:0] q_data,
   output logic             q_pop,
   output logic             q_sample,
   input  logic             flush,
   output logic             out_valid,
   output logic [MEM_W-1:0] out_data,
   output logic [SEQ_W-1:0] out_seq,
   input  logic             crd_rtn,
   output logic [CRD_W-1:0] credits,
   output logic             err_crd_ovf
);

   logic                 q_avail;
   logic                 send;
   logic                 pop;
   logic [STG_CNT_W-1:0] stg_cnt_w;
   logic [MEM_W-1:0]     stg_head;
   logic [CRD_W-1:0]     credits_q;
   logic [SEQ_W-1:0]     seq_q;
   logic                 err_q;
   logic                 crd_full;

   // Pop/send decision; nothing moves while reset is asserted or during a flush.
   always_comb begin
      q_avail  = !q_empty || q_push_any;
      send     = (stg_cnt_w != '0) && (credits_q != '0) && !flush && !reset;
      pop      = q_avail && !flush && !reset &&
                 ((stg_cnt_w != stg_cnt(STG_TWO)) || send);
      crd_full = (credits_q == CRD_W'(CREDITS));
   end

   ccp_skid_buf2 #(
      .W (MEM_W)
   ) u_stg (
      .clk     (clk),
      .reset   (reset),
      .wr      (pop),
      .rd      (send),
      .clr     (flush),
      .wr_data (q_data),
      .head    (stg_head),
      .cnt     (stg_cnt_w)
   );

   // Credit counter with saturating overflow detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         credits_q <= CRD_W'(CREDITS);
         err_q     <= 1'b0;
      end else begin
         if (send && !crd_rtn)                    credits_q <= credits_q - CRD_W'(1);
         else if (crd_rtn && !send && !crd_full)  credits_q <= credits_q + CRD_W'(1);
         if (crd_rtn && crd_full)                 err_q     <= 1'b1;
      end
   end

   // Sequence tag advances once per entry sent.
   always_ff @(posedge clk) begin
      if (reset)     seq_q <= '0;
      else if (send) seq_q <= seq_q + SEQ_W'(1);
   end

   assign q_pop       = pop;
   assign q_sample    = pop;
   assign out_valid   = send;
   assign out_data    = send ? stg_head : '0;
   assign out_seq     = seq_q;
   assign credits     = credits_q;
   assign err_crd_ovf = err_q;

endmodule

// File: tb/tb_ccp_ctrl_pop_stage.sv
// Directed self-checking bench for ccp_ctrl_pop_stage.
module tb_ccp_ctrl_pop_stage;

   localparam int unsigned MEM_W   = 4;
   localparam int unsigned CREDITS = 4;
   localparam int unsigned SEQ_W   = 4;
   localparam int unsigned CRD_W   = $clog2(CREDITS + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             q_empty;
   logic             q_push_any;
   logic [MEM_W-1:0] q_data;
   logic             q_pop;
   logic             q_sample;
   logic             flush;
   logic             out_valid;
   logic [MEM_W-1:0] out_data;
   logic [SEQ_W-1:0] out_seq;
   logic             crd_rtn;
   logic [CRD_W-1:0] credits;
   logic             err_crd_ovf;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ccp_ctrl_pop_stage #(
      .MEM_W   (MEM_W),
      .CREDITS (CREDITS),
      .SEQ_W   (SEQ_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .q_empty     (q_empty),
      .q_push_any  (q_push_any),
      .q_data      (q_data),
      .q_pop       (q_pop),
      .q_sample    (q_sample),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_seq     (out_seq),
      .crd_rtn     (crd_rtn),
      .credits     (credits),
      .err_crd_ovf (err_crd_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Advance to just after the next rising edge; inputs are then driven.
   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1; q_empty = 1'b1; q_push_any = 1'b0; q_data = '0;
      flush = 1'b0; crd_rtn = 1'b0;
      next_cyc();
      next_cyc();
      reset = 1'b0;
   endtask

   // T3 expected per-cycle pop/send pattern; data values are the entry numbers.
   logic       t3_pop [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 1};
   logic       t3_vld [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 1};
   logic [3:0] t3_dat [9] = '{0, 1, 2, 3, 4, 0, 0, 0, 5};
   logic [3:0] t3_seq [9] = '{0, 0, 1, 2, 3, 0, 0, 0, 4};

   initial begin
      int sends;
      logic [3:0] nxt;

      // Reset state
      do_reset();
      settle();
      chk("rst_credits", 32'(credits), 32'(CREDITS));
      chk("rst_err", 32'(err_crd_ovf), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_seq", 32'(out_seq), 0);
      chk("rst_pop", 32'(q_pop), 0);

      // T1: head available, one-cycle latency to send
      next_cyc();
      q_empty = 1'b0; q_data = 4'h5;
      settle();
      chk("t1_pop", 32'(q_pop), 1);
      chk("t1_sample", 32'(q_sample), 1);
      chk("t1_valid0", 32'(out_valid), 0);
      next_cyc();
      q_empty = 1'b1;
      settle();
      chk("t1_valid1", 32'(out_valid), 1);
      chk("t1_data1", 32'(out_data), 32'h5);
      chk("t1_seq1", 32'(out_seq), 0);
      chk("t1_pop1", 32'(q_pop), 0);
      next_cyc();
      settle();
      chk("t1_credits", 32'(credits), 3);
      chk("t1_valid2", 32'(out_valid), 0);

      // T2: bypass pop while empty, then no pop without availability
      next_cyc();
      q_push_any = 1'b1; q_data = 4'hA;
      settle();
      chk("t2_pop", 32'(q_pop), 1);
      chk("t2_sample", 32'(q_sample), 1);
      next_cyc();
      q_push_any = 1'b0;
      settle();
      chk("t2_valid", 32'(out_valid), 1);
      chk("t2_data", 32'(out_data), 32'hA);
      chk("t2_seq", 32'(out_seq), 1);
      for (int i = 0; i < 3; i++) begin
         next_cyc();
         settle();
         chk("t2_nopop", 32'(q_pop), 0);
      end
      chk("t2_credits", 32'(credits), 2);

      // T3: credit exhaustion with continuous availability
      do_reset();
      nxt = 4'h1;
      sends = 0;
      for (int c = 0; c < 9; c++) begin
         if (c != 0) next_cyc();
         q_empty = 1'b0;
         q_data  = nxt;
         crd_rtn = (c == 7);
         settle();
         chk("t3_pop", 32'(q_pop), 32'(t3_pop[c]));
         chk("t3_valid", 32'(out_valid), 32'(t3_vld[c]));
         if (t3_vld[c]) begin
            chk("t3_data", 32'(out_data), 32'(t3_dat[c]));
            chk("t3_seq", 32'(out_seq), 32'(t3_seq[c]));
         end
         if (out_valid && c < 8) sends++;
         if (t3_pop[c]) nxt = nxt + 4'h1;
      end
      chk("t3_sends", 32'(sends), 4);

      // T5: flush with two staged entries, credit returned during flush
      next_cyc();
      crd_rtn = 1'b1; flush = 1'b1; q_empty = 1'b0; q_data = 4'h9;
      settle();
      chk("t5_pop", 32'(q_pop), 0);
      chk("t5_valid", 32'(out_valid), 0);
      next_cyc();
      crd_rtn = 1'b0; flush = 1'b0; q_empty = 1'b1;
      settle();
      chk("t5_credits", 32'(credits), 1);
      chk("t5_empty", 32'(out_valid), 0);
      next_cyc();
      q_empty = 1'b0; q_data = 4'hC;
      settle();
      chk("t5_pop2", 32'(q_pop), 1);
      next_cyc();
      q_empty = 1'b1;
      settle();
      chk("t5_valid2", 32'(out_valid), 1);
      chk("t5_data2", 32'(out_data), 32'hC);
      chk("t5_seq2", 32'(out_seq), 5);

      // T4: return all credits, then one too many
      for (int i = 0; i < 4; i++) begin
         next_cyc();
         crd_rtn = 1'b1;
      end
      next_cyc();
      settle();
      chk("t4_full", 32'(credits), 4);
      chk("t4_noerr", 32'(err_crd_ovf), 0);
      next_cyc();
      crd_rtn = 1'b0;
      settle();
      chk("t4_err", 32'(err_crd_ovf), 1);
      chk("t4_hold", 32'(credits), 4);
      next_cyc();
      settle();
      chk("t4_sticky", 32'(err_crd_ovf), 1);
      // three entries; third sent alongside a credit return at credits==2
      q_empty = 1'b0; q_data = 4'h1;
      next_cyc();
      q_data = 4'h2;
      next_cyc();
      q_data = 4'h3;
      next_cyc();
      q_empty = 1'b1; crd_rtn = 1'b1;
      settle();
      chk("t4_cr2", 32'(credits), 2);
      chk("t4_valid", 32'(out_valid), 1);
      chk("t4_data", 32'(out_data), 32'h3);
      chk("t4_seq", 32'(out_seq), 8);
      next_cyc();
      crd_rtn = 1'b0;
      settle();
      chk("t4_same", 32'(credits), 2);

      // T6: reset with two staged entries and one credit
      q_empty = 1'b0; q_data = 4'h7;
      next_cyc();
      next_cyc();
      next_cyc();
      next_cyc();
      q_empty = 1'b1; crd_rtn = 1'b1;
      next_cyc();
      crd_rtn = 1'b0; reset = 1'b1; q_empty = 1'b0;
      settle();
      chk("t6_precr", 32'(credits), 1);
      chk("t6_rvalid", 32'(out_valid), 0);
      chk("t6_rpop", 32'(q_pop), 0);
      next_cyc();
      reset = 1'b0; q_empty = 1'b1;
      settle();
      chk("t6_credits", 32'(credits), 32'(CREDITS));
      chk("t6_valid", 32'(out_valid), 0);
      chk("t6_data", 32'(out_data), 0);
      chk("t6_seq", 32'(out_seq), 0);
      chk("t6_err", 32'(err_crd_ovf), 0);
      next_cyc();
      settle();
      chk("t6_drop", 32'(out_valid), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
